// File: rtl/pmp_pkg.sv
// PMP CSR encodings, pmpcfg field positions and the raw CSR shadow layout.
package pmp_pkg;
  import river_cfg_pkg::*;

  localparam int PMP_IW = $clog2(CFG_PMP_TBL_SIZE);

  localparam logic [1:0] PMP_A_OFF   = 2'd0;
  localparam logic [1:0] PMP_A_TOR   = 2'd1;
  localparam logic [1:0] PMP_A_NA4   = 2'd2;
  localparam logic [1:0] PMP_A_NAPOT = 2'd3;

  localparam int PMP_CFG_R    = 0;
  localparam int PMP_CFG_W    = 1;
  localparam int PMP_CFG_X    = 2;
  localparam int PMP_CFG_A_LO = 3;
  localparam int PMP_CFG_A_HI = 4;
  localparam int PMP_CFG_L    = 7;

  typedef struct packed {
    logic [CFG_PMP_TBL_SIZE-1:0][7:0]            cfg;
    logic [CFG_PMP_TBL_SIZE-1:0][RISCV_ARCH-1:0] addr;
  } PmpCsrShadowType;

  function automatic logic [1:0] pmp_cfg_a(input logic [7:0] cfg);
    return cfg[PMP_CFG_A_HI:PMP_CFG_A_LO];
  endfunction

endpackage

// File: rtl/river_cfg_pkg.sv
// Core-wide configuration: architecture width, PMP table geometry, flag bit positions.
package river_cfg_pkg;

  localparam int RISCV_ARCH       = 32;
  localparam int CFG_PMP_TBL_SIZE = 8;

  localparam int CFG_PMP_FL_R     = 0;
  localparam int CFG_PMP_FL_W     = 1;
  localparam int CFG_PMP_FL_X     = 2;
  localparam int CFG_PMP_FL_L     = 3;
  localparam int CFG_PMP_FL_V     = 4;
  localparam int CFG_PMP_FL_TOTAL = 5;

  typedef struct packed {
    logic [RISCV_ARCH-1:0]       start_addr;
    logic [RISCV_ARCH-1:0]       end_addr;
    logic [CFG_PMP_FL_TOTAL-1:0] flags;
  } PmpTableItemType;

endpackage

// File: rtl/pmp_region_calc.sv
// Combinational decode of one pmpcfg/pmpaddr pair into byte start, inclusive end and flags.
module pmp_region_calc
  import river_cfg_pkg::*;
  import pmp_pkg::*;
(
  input  logic [7:0]                  i_cfg,
  input  logic [RISCV_ARCH-1:0]       i_addr,
  input  logic [RISCV_ARCH-1:0]       i_prev_addr,
  input  logic                        i_idx_is_zero,
  output logic [RISCV_ARCH-1:0]       o_start,
  output logic [RISCV_ARCH-1:0]       o_end,
  output logic [CFG_PMP_FL_TOTAL-1:0] o_flags
);

  logic [RISCV_ARCH-1:0] w_p;
  logic [RISCV_ARCH-1:0] w_prev_p;
  logic [RISCV_ARCH-1:0] w_mask;
  logic [RISCV_ARCH-1:0] w_base;
  logic [RISCV_ARCH-1:0] w_napot_start;
  logic [RISCV_ARCH-1:0] w_tor_start;
  logic                  w_valid;
  logic                  w_unused_cfg;

  assign w_p      = {i_addr[RISCV_ARCH-3:0], 2'b00};
  assign w_prev_p = {i_prev_addr[RISCV_ARCH-3:0], 2'b00};

  // Mask covers the trailing ones of pmpaddr plus the first zero above them.
  assign w_mask        = i_addr ^ (i_addr + RISCV_ARCH'(1));
  assign w_base        = i_addr & ~w_mask;
  assign w_napot_start = {w_base[RISCV_ARCH-3:0], 2'b00};
  assign w_tor_start   = i_idx_is_zero ? '0 : w_prev_p;

  assign w_unused_cfg = ^i_cfg[6:5];

  always_comb begin
    o_start = '0;
    o_end   = '0;
    w_valid = 1'b0;
    case (pmp_cfg_a(i_cfg))
      PMP_A_TOR: begin
        o_start = w_tor_start;
        o_end   = w_p - RISCV_ARCH'(1);
        w_valid = (w_p > w_tor_start);
      end
      PMP_A_NA4: begin
        o_start = w_p;
        o_end   = w_p + RISCV_ARCH'(3);
        w_valid = 1'b1;
      end
      PMP_A_NAPOT: begin
        o_start = w_napot_start;
        o_end   = w_napot_start | {w_mask[RISCV_ARCH-3:0], 2'b11};
        w_valid = 1'b1;
      end
      default: begin
        o_start = '0;
        o_end   = '0;
        w_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    o_flags               = '0;
    o_flags[CFG_PMP_FL_R] = i_cfg[PMP_CFG_R];
    o_flags[CFG_PMP_FL_W] = i_cfg[PMP_CFG_W];
    o_flags[CFG_PMP_FL_X] = i_cfg[PMP_CFG_X];
    o_flags[CFG_PMP_FL_L] = i_cfg[PMP_CFG_L];
    o_flags[CFG_PMP_FL_V] = w_valid;
  end

endmodule

// File: rtl/pmp_csr_decoder.sv
// Shadows pmpcfg/pmpaddr per entry, applies lock rules and emits registered PMP table writes
// (entry, then the following TOR entry when it depends on this entry's address).
module pmp_csr_decoder
  import river_cfg_pkg::*;
  import pmp_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic [PMP_IW-1:0]           i_req_idx,
  input  logic [7:0]                  i_req_cfg,
  input  logic [RISCV_ARCH-1:0]       i_req_addr,
  input  logic [PMP_IW-1:0]           i_rd_idx,
  output logic [7:0]                  o_rd_cfg,
  output logic [RISCV_ARCH-1:0]       o_rd_addr,
  output logic                        o_we,
  output logic [PMP_IW-1:0]           o_widx,
  output logic [RISCV_ARCH-1:0]       o_wstart,
  output logic [RISCV_ARCH-1:0]       o_wend,
  output logic [CFG_PMP_FL_TOTAL-1:0] o_wflags
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CUR  = 2'd1,
    WR_NEXT = 2'd2
  } state_t;

  localparam logic [PMP_IW-1:0] LAST_IDX = PMP_IW'(CFG_PMP_TBL_SIZE - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [PMP_IW-1:0]           r_idx;
  PmpCsrShadowType             r_shadow;
  logic                        r_we;
  logic [PMP_IW-1:0]           r_widx;
  PmpTableItemType             r_item;

  logic                        w_accept;
  logic [PMP_IW-1:0]           w_req_nidx;
  logic [PMP_IW-1:0]           w_req_pidx;
  logic                        w_cur_locked;
  logic                        w_next_tor_locked;
  logic [7:0]                  w_cfg_eff;
  logic [RISCV_ARCH-1:0]       w_addr_eff;
  logic [PMP_IW-1:0]           w_cur_nidx;
  logic                        w_chain;

  logic [7:0]                  w_calc_cfg;
  logic [RISCV_ARCH-1:0]       w_calc_addr;
  logic [RISCV_ARCH-1:0]       w_calc_prev;
  logic                        w_calc_first;
  logic [RISCV_ARCH-1:0]       w_calc_start;
  logic [RISCV_ARCH-1:0]       w_calc_end;
  logic [CFG_PMP_FL_TOTAL-1:0] w_calc_flags;
  PmpTableItemType             w_calc_item;

  assign o_req_ready = (r_state == IDLE);
  assign w_accept    = i_req_valid && (r_state == IDLE);

  assign w_req_nidx = i_req_idx + PMP_IW'(1);
  assign w_req_pidx = i_req_idx - PMP_IW'(1);

  // A locked TOR successor freezes this entry's address, since it forms its lower bound.
  assign w_cur_locked      = r_shadow.cfg[i_req_idx][PMP_CFG_L];
  assign w_next_tor_locked = (i_req_idx < LAST_IDX)
                          && (pmp_cfg_a(r_shadow.cfg[w_req_nidx]) == PMP_A_TOR)
                          && r_shadow.cfg[w_req_nidx][PMP_CFG_L];

  assign w_cfg_eff  = w_cur_locked ? r_shadow.cfg[i_req_idx] : i_req_cfg;
  assign w_addr_eff = (w_cur_locked || w_next_tor_locked) ? r_shadow.addr[i_req_idx] : i_req_addr;

  assign w_cur_nidx = r_idx + PMP_IW'(1);
  assign w_chain    = (r_idx < LAST_IDX) && (pmp_cfg_a(r_shadow.cfg[w_cur_nidx]) == PMP_A_TOR);

  // The current entry is decoded at accept from the post-update values so its strobe lands
  // one cycle later; the TOR successor is decoded in WR_CUR from the already-updated shadow.
  always_comb begin
    w_calc_cfg   = w_cfg_eff;
    w_calc_addr  = w_addr_eff;
    w_calc_prev  = r_shadow.addr[w_req_pidx];
    w_calc_first = (i_req_idx == '0);
    if (r_state != IDLE) begin
      w_calc_cfg   = r_shadow.cfg[w_cur_nidx];
      w_calc_addr  = r_shadow.addr[w_cur_nidx];
      w_calc_prev  = r_shadow.addr[r_idx];
      w_calc_first = 1'b0;
    end
  end

  pmp_region_calc u_calc (
    .i_cfg         (w_calc_cfg),
    .i_addr        (w_calc_addr),
    .i_prev_addr   (w_calc_prev),
    .i_idx_is_zero (w_calc_first),
    .o_start       (w_calc_start),
    .o_end         (w_calc_end),
    .o_flags       (w_calc_flags)
  );

  assign w_calc_item = {w_calc_start, w_calc_end, w_calc_flags};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = WR_CUR;
      WR_CUR:  w_state_next = w_chain ? WR_NEXT : IDLE;
      WR_NEXT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_idx    <= '0;
      r_shadow <= '0;
      r_we     <= 1'b0;
      r_widx   <= '0;
      r_item   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_idx                    <= i_req_idx;
        r_shadow.cfg[i_req_idx]  <= w_cfg_eff;
        r_shadow.addr[i_req_idx] <= w_addr_eff;
        r_we                     <= 1'b1;
        r_widx                   <= i_req_idx;
        r_item                   <= w_calc_item;
      end else if ((r_state == WR_CUR) && w_chain) begin
        r_we   <= 1'b1;
        r_widx <= w_cur_nidx;
        r_item <= w_calc_item;
      end
    end
  end

  assign o_rd_cfg  = r_shadow.cfg[i_rd_idx];
  assign o_rd_addr = r_shadow.addr[i_rd_idx];

  assign o_we     = r_we;
  assign o_widx   = r_widx;
  assign o_wstart = r_item.start_addr;
  assign o_wend   = r_item.end_addr;
  assign o_wflags = r_item.flags;

endmodule
